piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out shift register: accepts a WIDTH-bit word through a valid/ready load
//  handshake, then emits it one bit per clk with a qualifying valid strobe.
//  Transmit-side counterpart to the bit-capture storage path. Built from dff_sync_set_reset cells
//  plus gate logic. Used for serial buses and bit-serial datapath stages in the CPU.
// PARAMETERS
//  WIDTH      8  word length in bits; legal range is WIDTH >= 2
//  MSB_FIRST  1  1: emit data_in[WIDTH-1] first; 0: emit data_in[0] first
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  reset        in   1      synchronous, active-high; sampled on posedge clk
//  load_valid   in   1      producer offers data_in
//  load_ready   out  1      block can accept a word this cycle
//  data_in      in   WIDTH  parallel word; sampled only on an accepted load
//  ser_out      out  1      current serial bit; 0 whenever ser_valid=0
//  ser_valid    out  1      ser_out carries a valid bit this cycle
//  frame_start  out  1      high with the first bit of each word
//  done         out  1      high with the last bit of each word
// BEHAVIOUR
//  - Reset: on a posedge with reset=1, state=IDLE, shift reg=0, bit count=0. Outputs after that edge:
//    ser_out=0, ser_valid=0, frame_start=0, done=0, load_ready=1. Reset beats every other input.
//  - FSM states:
//    - IDLE: load_ready=1; ser_valid=0.
//    - SHIFT: ser_valid=1; load_ready=done.
//  - Accept: a load is accepted on a posedge where load_valid & load_ready & !reset.
//    - That edge loads the shift register from data_in, sets count=0 and enters SHIFT.
//  - Latency: the first bit is on ser_out in the cycle right after the accept edge, with frame_start=1.
//  - Shifting: each SHIFT cycle shows one bit. Shift toward the output end and fill the vacated bit with 0.
//    - Count increments each edge; width $clog2(WIDTH).
//    - Bit k (k=0..WIDTH-1) appears exactly k cycles after the first bit.
//  - Last bit: done=1 when count==WIDTH-1. On the next edge:
//    - with an accepted load: the new word loads, and its first bit follows with no gap (back-to-back).
//    - otherwise: go to IDLE.
//  - In SHIFT with count<WIDTH-1: load_ready=0 and load_valid is ignored; data_in is not sampled.
//  - Outputs are decoded from registered state only; no combinational path from load_valid or data_in to
//    ser_out/ser_valid/frame_start/done. load_ready is also decoded from state only.
//  - Reset mid-frame: the remaining bits are discarded. The cycle after the reset edge matches post-reset values.
//  - The count never exceeds WIDTH-1; wrap to 0 only happens through a new accept.
// STRUCTURE
//  - Shared package: FSM state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1.
//  - Storage: state bit, WIDTH-bit shift register and count register, all dff_sync_set_reset instances.
//    - reset ties to each cell's reset pin; set is tied 0.
//  - Sub-module: bit_counter (sync-reset incrementer with clear/enable, terminal-count compare
//    output), reused for other bit-serial blocks.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1: accept 8'hA5.
//     -> ser_out 1,0,1,0,0,1,0,1 over the next 8 cycles; ser_valid=1 for all 8;
//        frame_start on bit 1; done on bit 8; then ser_valid=0 and load_ready=1.
//  2. Back-to-back: load_valid held with 8'hFF, then 8'h00 offered while done=1.
//     -> 16 contiguous ser_valid cycles: eight 1s, then eight 0s; frame_start at cycles 1 and 9.
//  3. load_valid=1 with 8'h3C during bit 4 of 8'hA5.
//     -> load_ready=0, no accept, and the A5 bit stream is unchanged.
//  4. Reset asserted during bit 3.
//     -> the next cycle has ser_valid=0, ser_out=0, done=0 and load_ready=1; a fresh 8'h81 then serializes correctly.
//  5. load_valid=1 and reset=1 on the same edge.
//     -> no accept; the block stays IDLE with all outputs at reset values.
//  6. MSB_FIRST=0, accept 8'h01.
//     -> ser_out 1,0,0,0,0,0,0,0; done on the 8th bit.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Contents:
//   ST_IDLE / ST_SHIFT  - state encoding constants
//   state_t             - FSM state type built on those constants
package piso_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

endpackage

// File: rtl/dff_sync_set_reset.sv
// Storage cell: W-bit D flip-flop with synchronous reset and set.
// Reset has priority over set.
// Ports:
//   clk   in  1  clock, posedge
//   reset in  1  synchronous active-high clear to 0
//   set   in  1  synchronous active-high preset to all ones
//   d     in  W  next value
//   q     out W  registered value
module dff_sync_set_reset #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (set)
            q <= '1;
        else
            q <= d;
    end

endmodule

// File: rtl/piso_serializer_bit_counter.sv
// Bit counter for bit-serial blocks: synchronous-reset incrementer with
// clear and enable, plus a terminal-count compare output.
// Clear has priority over enable.
// Ports:
//   clk      in  1  clock, posedge
//   reset    in  1  synchronous active-high clear
//   clear    in  1  load 0 on the next edge
//   enable   in  1  increment on the next edge
//   count    out W  current count
//   terminal out 1  count equals TERMINAL
module bit_counter #(
    parameter int           W        = 3,
    parameter logic [W-1:0] TERMINAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (enable)
            count_next = count + W'(1);
    end

    dff_sync_set_reset #(.W(W)) u_count_reg (
        .clk   (clk),
        .reset (reset),
        .set   (1'b0),
        .d     (count_next),
        .q     (count)
    );

    assign terminal = (count == TERMINAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. A word accepted on the load handshake
// is emitted one bit per clock, starting the cycle after the accept edge.
// A new word may be accepted while the last bit is shown, giving gap-free
// back-to-back frames. All outputs decode registered state only.
// Ports:
//   clk         in  1      clock, posedge
//   reset       in  1      synchronous active-high reset
//   load_valid  in  1      producer offers data_in
//   load_ready  out 1      a word can be accepted this cycle
//   data_in     in  WIDTH  parallel word, sampled only on accept
//   ser_out     out 1      serial bit, 0 when ser_valid=0
//   ser_valid   out 1      ser_out carries a bit
//   frame_start out 1      first bit of a word
//   done        out 1      last bit of a word
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam int             OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    state_t           state;
    state_t           state_next;
    logic             state_q;
    logic             state_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;

    assign state   = state_t'(state_q);
    assign state_d = state_next;

    always_comb begin
        state_next = state;
        ser_valid  = 1'b0;
        load_ready = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_valid)
                    state_next = S_SHIFT;
            end
            S_SHIFT: begin
                ser_valid  = 1'b1;
                done       = last;
                load_ready = last;
                // On the last bit a waiting word keeps us in SHIFT (no gap).
                if (last && !load_valid)
                    state_next = S_IDLE;
            end
        endcase
    end

    assign accept      = load_valid & load_ready;
    assign frame_start = ser_valid & (count == '0);
    assign ser_out     = ser_valid & shreg[OUT_IDX];

    // Shift toward the output end; the vacated bit fills with 0.
    always_comb begin
        shreg_next = shreg;
        if (accept)
            shreg_next = data_in;
        else if (ser_valid)
            shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};
    end

    dff_sync_set_reset #(.W(1)) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .set   (1'b0),
        .d     (state_d),
        .q     (state_q)
    );

    dff_sync_set_reset #(.W(WIDTH)) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .set   (1'b0),
        .d     (shreg_next),
        .q     (shreg)
    );

    // Count holds at WIDTH-1 after the last bit; only an accept restarts it.
    bit_counter #(.W(CW), .TERMINAL(LAST)) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (ser_valid & ~last),
        .count    (count),
        .terminal (last)
    );

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic so_m, sv_m, fs_m, dn_m, lr_m;
    logic so_l, sv_l, fs_l, dn_l, lr_l;

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view (busy flag, held word, bit index)
    bit         m_busy = 1'b0;
    int         m_k = 0;
    logic [7:0] m_word = 8'h00;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_m),
        .data_in(data_in), .ser_out(so_m), .ser_valid(sv_m),
        .frame_start(fs_m), .done(dn_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_l),
        .data_in(data_in), .ser_out(so_l), .ser_valid(sv_l),
        .frame_start(fs_l), .done(dn_l)
    );

    typedef struct {
        logic       r;
        logic       lv;
        logic [7:0] d;
        logic       so_m;
        logic       so_l;
        logic       sv;
        logic       fs;
        logic       dn;
        logic       lr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic bm, bl;
        bm = m_busy ? m_word[7 - m_k] : 1'b0;
        bl = m_busy ? m_word[m_k]     : 1'b0;
        chk("mdl_so_m", so_m, bm);
        chk("mdl_sv_m", sv_m, m_busy);
        chk("mdl_fs_m", fs_m, m_busy && m_k == 0);
        chk("mdl_dn_m", dn_m, m_busy && m_k == 7);
        chk("mdl_lr_m", lr_m, !m_busy || m_k == 7);
        chk("mdl_so_l", so_l, bl);
        chk("mdl_sv_l", sv_l, m_busy);
        chk("mdl_fs_l", fs_l, m_busy && m_k == 0);
        chk("mdl_dn_l", dn_l, m_busy && m_k == 7);
        chk("mdl_lr_l", lr_l, !m_busy || m_k == 7);
    endtask

    task automatic tick(input logic r, input logic lv, input logic [7:0] d);
        bit ready;
        reset      = r;
        load_valid = lv;
        data_in    = d;
        @(posedge clk);
        ready = !m_busy || m_k == 7;
        if (r) begin
            m_busy = 1'b0;
        end else if (lv && ready) begin
            m_busy = 1'b1;
            m_word = d;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == 7) m_busy = 1'b0;
            else          m_k++;
        end
        #1;
        check_model();
    endtask

    function automatic vec_t mk(logic r, logic lv, logic [7:0] d, logic som, logic sol,
                                logic sv, logic fs, logic dn, logic lr);
        vec_t v;
        v.r = r; v.lv = lv; v.d = d; v.so_m = som; v.so_l = sol;
        v.sv = sv; v.fs = fs; v.dn = dn; v.lr = lr;
        return v;
    endfunction

    initial begin
        logic [15:0] bits16, fs16;
        logic [7:0]  b8m, b8l;
        int          nvalid;

        // Reset, A5 frame (same stream both bit orders), idle
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 8'hA5, 1, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
        // Reset and load_valid on the same edge: no accept
        vt.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));
        // 01 frame: MSB-first shows 1 last, LSB-first shows 1 first
        vt.push_back(mk(0, 1, 8'h01, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].r, vt[i].lv, vt[i].d);
            chk("tbl_so_m", so_m, vt[i].so_m);
            chk("tbl_so_l", so_l, vt[i].so_l);
            chk("tbl_sv",   sv_m, vt[i].sv);
            chk("tbl_fs",   fs_m, vt[i].fs);
            chk("tbl_done", dn_m, vt[i].dn);
            chk("tbl_lr",   lr_m, vt[i].lr);
        end

        // Back-to-back FF then 00
        bits16 = '0; fs16 = '0; nvalid = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1'b0, c <= 8, (c == 8) ? 8'h00 : 8'hFF);
            bits16 = {bits16[14:0], so_m};
            fs16   = {fs16[14:0], fs_m};
            nvalid += int'(sv_m);
        end
        chk("b2b_bits", bits16, 16'hFF00);
        chk("b2b_frame_start", fs16, 16'h8080);
        chk("b2b_valid_cnt", nvalid, 16);
        tick(1'b0, 1'b0, 8'h00);
        chk("b2b_idle_sv", sv_m, 1'b0);

        // Load offered mid-frame is ignored
        b8m = '0;
        tick(1'b0, 1'b1, 8'hA5);
        b8m = {b8m[6:0], so_m};
        for (int c = 1; c < 8; c++) begin
            if (c == 4) chk("mid_lr", lr_m, 1'b0);
            tick(1'b0, c == 4, 8'h3C);
            b8m = {b8m[6:0], so_m};
        end
        chk("mid_stream", b8m, 8'hA5);
        tick(1'b0, 1'b0, 8'h00);
        chk("mid_after_sv", sv_m, 1'b0);
        chk("mid_after_lr", lr_m, 1'b1);

        // Reset during bit 3, then a fresh 81
        tick(1'b0, 1'b1, 8'hA5);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("rst_sv", sv_m, 1'b0);
        chk("rst_so", so_m, 1'b0);
        chk("rst_done", dn_m, 1'b0);
        chk("rst_lr", lr_m, 1'b1);
        b8m = '0; b8l = '0;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, c == 0, 8'h81);
            b8m = {b8m[6:0], so_m};
            b8l = {b8l[6:0], so_l};
        end
        chk("rst_fresh_m", b8m, 8'h81);
        chk("rst_fresh_l", b8l, 8'h81);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(63) == 0, 1'($urandom_range(1)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
